// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the serial ALU datapath.
package alu_pkg;

   typedef logic [1:0] alu_op_t;

   localparam alu_op_t OP_NOR = 2'b00;
   localparam alu_op_t OP_XOR = 2'b01;
   localparam alu_op_t OP_ADD = 2'b10;
   localparam alu_op_t OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } alu_state_t;

   function automatic logic is_arith(input alu_op_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: NOR/XOR/ADD/SUB, purely combinational, no flow control.
// The carry/borrow output is 0 for logic ops so a chain of slices never leaks carry.
module alu1bit
   import alu_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    cin,
   input  alu_op_t op,
   output logic    s,
   output logic    cout
);

   always_comb begin
      s    = 1'b0;
      cout = 1'b0;
      case (op)
         OP_NOR: s = ~(a | b);
         OP_XOR: s = a ^ b;
         OP_ADD: begin
            s    = a ^ b ^ cin;
            cout = (a & b) | (a & cin) | (b & cin);
         end
         OP_SUB: begin
            s    = a ^ b ^ cin;
            cout = (~a & b) | (~a & cin) | (b & cin);
         end
         default: begin
            s    = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Serial ALU stepping LANES slices per cycle over WIDTH-bit operands; start/done handshake.
// Latency WIDTH/LANES cycles of busy, then a one-cycle done; start is ignored while busy.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             zero
);

   localparam int STEPS = WIDTH / LANES;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'({LANES{1'b1}});

   alu_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   alu_op_t          op_q, op_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;

   logic [LANES-1:0] lane_a, lane_b, lane_s;
   logic [LANES:0]   lane_c;
   int               shamt;

   assign shamt  = int'(cnt_q) * LANES;
   assign lane_a = LANES'(a_q >> shamt);
   assign lane_b = LANES'(b_q >> shamt);
   assign lane_c[0] = carry_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      alu1bit u_bit (
         .a    (lane_a[i]),
         .b    (lane_b[i]),
         .cin  (lane_c[i]),
         .op   (op_q),
         .s    (lane_s[i]),
         .cout (lane_c[i+1])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      zero_d  = zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               op_d    = alu_op_t'(op);
               carry_d = is_arith(alu_op_t'(op)) ? cin : 1'b0;
               cnt_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               zero_d  = 1'b0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            s_d     = (s_q & ~(LANE_MASK << shamt)) | (WIDTH'(lane_s) << shamt);
            carry_d = is_arith(op_q) ? lane_c[LANES] : 1'b0;
            cnt_d   = cnt_q + CW'(1);
            // Flags are committed together with the final slice so they are valid in DONE.
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               cout_d  = carry_d;
               zero_d  = (s_d == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_NOR;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign zero = zero_q;

endmodule
